// File: rtl/pdcch_pkg.sv
// pdcch_pkg: shared constants and state type for the PDCCH Gold sequence generator
package pdcch_pkg;
  localparam int NC = 1600;
  localparam logic [30:0] X1_RST = 31'h0;
  localparam logic [30:0] X2_RST = 31'h0;
  localparam logic [30:0] X1_INIT = 31'h1;
  localparam logic [30:0] X1_TAPS = 31'h0000_0009;
  localparam logic [30:0] X2_TAPS = 31'h0000_000f;
  typedef enum logic [1:0] {IDLE, WARMUP, RUN} gold_state_e;
endpackage

// File: rtl/pdcch_gold_lfsr_adv.sv
// pdcch_gold_lfsr_adv: advances a 31-bit Fibonacci LFSR by STEPS steps in one cycle
// State bit i holds x(n+i); the feedback bit x(n+31) is the parity of the tapped bits.
module pdcch_gold_lfsr_adv #(
  parameter int STEPS = 8,
  parameter logic [30:0] TAPS = 31'h9
) (
  input  logic [30:0] state_i,
  output logic [30:0] state_o
);
  always_comb begin
    logic [30:0] s;
    s = state_i;
    for (int i = 0; i < STEPS; i++) s = {^(s & TAPS), s[30:1]};
    state_o = s;
  end
endmodule

// File: rtl/pdcch_gold_seq_gen.sv
// pdcch_gold_seq_gen: 38.211 Gold sequence generator emitting OUT_W bits per AXI-Stream beat
// Bit 0 of each LFSR is x(n+Nc) once warm, so output bit k is simply x1[k]^x2[k].
module pdcch_gold_seq_gen
  import pdcch_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_axis_valid,
  input  logic [30:0]      s_axis_cinit,
  input  logic [LEN_W-1:0] s_axis_len,
  output logic             s_axis_ready,
  output logic [OUT_W-1:0] m_axis_data,
  output logic             m_axis_valid,
  output logic             m_axis_last,
  input  logic             m_axis_ready
);
  localparam int SH = $clog2(OUT_W);
  localparam int WARM = NC / OUT_W;
  gold_state_e state_q, state_d;
  logic [30:0] x1_q, x1_d, x2_q, x2_d, x1_nx, x2_nx;
  logic [10:0] wcnt_q, wcnt_d;
  logic [LEN_W:0] beats_q, beats_d, beats_in;
  logic [LEN_W-1:0] rem;
  logic [OUT_W-1:0] mask_q, mask_d, mask_in;
  pdcch_gold_lfsr_adv #(.STEPS(OUT_W), .TAPS(X1_TAPS)) u_x1 (.state_i(x1_q), .state_o(x1_nx));
  pdcch_gold_lfsr_adv #(.STEPS(OUT_W), .TAPS(X2_TAPS)) u_x2 (.state_i(x2_q), .state_o(x2_nx));
  // one extra bit keeps ceil(len/OUT_W) exact for len near 2^LEN_W-1
  assign beats_in = ({1'b0, s_axis_len} + (LEN_W+1)'(OUT_W - 1)) >> SH;
  assign rem = s_axis_len & LEN_W'(OUT_W - 1);
  assign mask_in = (rem == '0) ? '1 : ~({OUT_W{1'b1}} << rem);
  assign s_axis_ready = state_q == IDLE;
  assign m_axis_valid = state_q == RUN;
  assign m_axis_last = m_axis_valid && beats_q == (LEN_W+1)'(1);
  assign m_axis_data = m_axis_valid ? (x1_q[OUT_W-1:0] ^ x2_q[OUT_W-1:0]) & (m_axis_last ? mask_q : '1) : '0;
  always_comb begin
    state_d = state_q;
    x1_d = x1_q;
    x2_d = x2_q;
    wcnt_d = wcnt_q;
    beats_d = beats_q;
    mask_d = mask_q;
    case (state_q)
      IDLE: if (s_axis_valid && s_axis_len != '0) begin
        state_d = WARMUP;
        x1_d = X1_INIT;
        x2_d = s_axis_cinit;
        wcnt_d = '0;
        beats_d = beats_in;
        mask_d = mask_in;
      end
      WARMUP: begin
        x1_d = x1_nx;
        x2_d = x2_nx;
        wcnt_d = wcnt_q + 11'd1;
        state_d = (wcnt_q == 11'(WARM - 1)) ? RUN : WARMUP;
      end
      RUN: if (m_axis_ready) begin
        x1_d = x1_nx;
        x2_d = x2_nx;
        beats_d = beats_q - (LEN_W+1)'(1);
        state_d = m_axis_last ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x1_q <= X1_RST;
      x2_q <= X2_RST;
      wcnt_q <= '0;
      beats_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      wcnt_q <= wcnt_d;
      beats_q <= beats_d;
      mask_q <= mask_d;
    end
  end
endmodule

// File: tb/tb_pdcch_gold_seq_gen.sv
// tb_pdcch_gold_seq_gen: random-stimulus bench against a bit-serial Gold sequence model
module tb_pdcch_gold_seq_gen;
  localparam int OUT_W = 8;
  localparam int LEN_W = 16;
  localparam int NC = 1600;
  localparam int WARM = NC / OUT_W;
  logic clk = 0, reset = 1, s_axis_valid = 0, m_axis_ready = 0;
  logic [30:0] s_axis_cinit = '0;
  logic [LEN_W-1:0] s_axis_len = '0;
  logic s_axis_ready, m_axis_valid, m_axis_last;
  logic [OUT_W-1:0] m_axis_data;
  int checks = 0, failures = 0, beats_seen = 0;
  typedef struct packed {logic [OUT_W-1:0] d; logic l;} beat_t;
  beat_t exp_q[$];
  bit bp_en = 0;
  time last_hs_t = 0;
  logic [OUT_W-1:0] last_data = '0;
  pdcch_gold_seq_gen #(.OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .s_axis_valid(s_axis_valid), .s_axis_cinit(s_axis_cinit),
    .s_axis_len(s_axis_len), .s_axis_ready(s_axis_ready), .m_axis_data(m_axis_data),
    .m_axis_valid(m_axis_valid), .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // c(n) = x1(n+nc) ^ x2(n+nc), generated bit-serially from the recursions
  function automatic bit gold_c(input logic [30:0] ci, input int nc, input int n);
    bit x1[], x2[];
    int t = nc + n;
    x1 = new[t + 32];
    x2 = new[t + 32];
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = ci[i];
    end
    for (int m = 0; m + 31 <= t; m++) begin
      x1[m+31] = x1[m+3] ^ x1[m];
      x2[m+31] = x2[m+3] ^ x2[m+2] ^ x2[m+1] ^ x2[m];
    end
    return x1[t] ^ x2[t];
  endfunction
  task automatic push_model(input logic [30:0] ci, input int len);
    int beats = (len + OUT_W - 1) / OUT_W;
    beat_t bt;
    for (int b = 0; b < beats; b++) begin
      bt.d = '0;
      for (int k = 0; k < OUT_W; k++)
        if (b * OUT_W + k < len) bt.d[k] = gold_c(ci, NC, b * OUT_W + k);
      bt.l = (b == beats - 1);
      exp_q.push_back(bt);
    end
  endtask
  task automatic send(input logic [30:0] ci, input int len, input bit b2b);
    int n = 0;
    @(posedge clk); #1;
    s_axis_valid = 1;
    s_axis_cinit = ci;
    s_axis_len = LEN_W'(len);
    do begin @(negedge clk); n++; end while (!s_axis_ready && n < 5000);
    if (!s_axis_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end else begin
      if (b2b) begin
        chk("b2b_accept_gap", 32'($time - last_hs_t), 32'd10);
        chk("b2b_prev_done", exp_q.size(), 0);
      end
      if (len != 0) push_model(ci, len);
    end
    @(posedge clk); #1;
    s_axis_valid = 0;
  endtask
  task automatic first_valid(output int n);
    n = 0;
    do begin @(posedge clk); n++; @(negedge clk); end while (!m_axis_valid && n < 1000);
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    chk({nm, "_drained"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk({nm, "_idle_ready"}, s_axis_ready, 1);
  endtask
  task automatic hit_reset(input string nm);
    @(posedge clk); #2;
    reset = 1;
    #1;
    chk({nm, "_valid"}, m_axis_valid, 0);
    chk({nm, "_data"}, m_axis_data, 0);
    chk({nm, "_last"}, m_axis_last, 0);
    chk({nm, "_sready"}, s_axis_ready, 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 reset = 0;
  endtask
  initial forever begin
    @(posedge clk); #1;
    m_axis_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial begin
    logic [OUT_W-1:0] pd = '0;
    logic pl = 0, pstall = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_valid", m_axis_valid, 0);
        chk("rst_data", m_axis_data, 0);
        chk("rst_sready", s_axis_ready, 1);
        pstall = 0;
      end else if (m_axis_valid) begin
        chk("busy_sready", s_axis_ready, 0);
        if (pstall) begin
          chk("stall_data", m_axis_data, pd);
          chk("stall_last", m_axis_last, pl);
        end
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL residual_beat actual=%0h required=no_beat", m_axis_data);
        end else begin
          chk("beat_data", m_axis_data, exp_q[0].d);
          chk("beat_last", m_axis_last, exp_q[0].l);
          if (m_axis_ready) begin
            if (m_axis_last) begin
              last_hs_t = $time;
              last_data = m_axis_data;
            end
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
        pstall = !m_axis_ready;
        pd = m_axis_data;
        pl = m_axis_last;
      end else pstall = 0;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    chk("pin_c0_ci0", 32'(gold_c(31'h0, 0, 0)), 1);
    chk("pin_c1_ci0", 32'(gold_c(31'h0, 0, 1)), 0);
    chk("pin_c31_ci0", 32'(gold_c(31'h0, 0, 31)), 1);
    chk("pin_c62_ci0", 32'(gold_c(31'h0, 0, 62)), 1);
    chk("pin_c31_ci1", 32'(gold_c(31'h1, 0, 31)), 0);
    chk("pin_c1_ci2", 32'(gold_c(31'h2, 0, 1)), 1);
    chk("pin_c33_ci4", 32'(gold_c(31'h4, 0, 33)), 1);
    #2;
    chk("por_valid", m_axis_valid, 0);
    chk("por_last", m_axis_last, 0);
    chk("por_data", m_axis_data, 0);
    chk("por_sready", s_axis_ready, 1);
    @(posedge clk); #3 reset = 0;
    beats_seen = 0;
    send(31'h1234, 64, 0);
    first_valid(lat);
    chk("latency", lat, WARM);
    drain("len64");
    chk("len64_beats", beats_seen, 8);
    beats_seen = 0;
    send(31'h5a5a5a5, 20, 0);
    chk("model_len20_beats", exp_q.size(), 3);
    drain("len20");
    chk("len20_beats", beats_seen, 3);
    chk("len20_tail", 32'(last_data[7:4]), 0);
    bp_en = 1;
    beats_seen = 0;
    send(31'h7fffffff, 100, 0);
    drain("len100_bp");
    chk("len100_beats", beats_seen, 13);
    send(31'h1, 0, 0);
    repeat (300) @(negedge clk);
    chk("len0_sready", s_axis_ready, 1);
    chk("len0_no_model", exp_q.size(), 0);
    send(31'h0abcdef, 20, 0);
    send(31'h3141592, 37, 1);
    drain("b2b");
    send(31'h2468ace, 64, 0);
    repeat (50) @(posedge clk);
    hit_reset("warm_rst");
    repeat (300) @(negedge clk);
    send(31'h1357bdf, 64, 0);
    first_valid(lat);
    chk("post_rst_latency", lat, WARM);
    repeat (3) @(posedge clk);
    hit_reset("run_rst");
    repeat (300) @(negedge clk);
    send(31'h1234, 64, 0);
    drain("after_rst");
    for (int i = 0; i < 6; i++) begin
      send(31'($urandom), $urandom_range(1, 100), 0);
      drain("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
